// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-requester arbiter in front of a single-port data memory.
//   Requester 0 is the core load/store path, requester 1 the debug/DMA port.
//   One memory access is issued every two cycles (IDLE -> ACCESS -> IDLE).
//   Read data is returned through a registered response one cycle after
//   the access cycle.
//
//   Optional feature macro: DMEM_ARB_PERF_EN
//     defined   -> cnt0/cnt1 saturating grant counters (CNT_W bits) present
//     undefined -> counter ports and logic absent, behaviour otherwise identical
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for a request; winner is latched at the next edge
//   S_ACCESS | latched access driven onto the memory port for one cycle
module data_mem_arbiter #(
  parameter int DATA       = 32,
  parameter int ADDR       = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] wdata0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DATA-1:0] rdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] wdata1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DATA-1:0] rdata1,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_a,
  output logic [DATA-1:0] mem_wd,
  input  logic [DATA-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // Counter width is checked in both builds so a bad override is caught
  // even when the counters are compiled out.
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("data_mem_arbiter: CNT_W must be at least 1");
  end

  logic [0:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic [DATA-1:0] rdata0_q, rdata0_d;
  logic [DATA-1:0] rdata1_q, rdata1_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;

  logic            any_req;
  logic            winner;
  logic            win_we;
  logic [ADDR-1:0] win_addr;
  logic [DATA-1:0] win_wdata;
  logic            in_access;
  logic            access_live;

  assign in_access = (state_q == S_ACCESS);
  // An access caught by reset is dropped: nothing it drives may escape.
  assign access_live = in_access & ~rst;

  // Winner selection: a lone request wins outright; on a tie either
  // requester 0 wins (fixed priority) or the one that was not served last.
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      if (FIXED_PRIO != 0) begin
        winner = 1'b0;
      end else begin
        winner = ~last_owner_q;
      end
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Mux the winning requester's access fields for latching.
  always_comb begin
    win_we    = we0;
    win_addr  = addr0;
    win_wdata = wdata0;
    if (winner) begin
      win_we    = we1;
      win_addr  = addr1;
      win_wdata = wdata1;
    end
  end

  // FSM next state plus latched access and read response capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d      = S_ACCESS;
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = win_we;
          addr_d       = win_addr;
          wdata_d      = win_wdata;
        end
      end
      S_ACCESS: begin
        // Requests are not looked at here; the access always takes one cycle.
        state_d = S_IDLE;
        if (!we_q) begin
          if (owner_q) begin
            rdata1_d  = mem_rd;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rd;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; last_owner resets to 1 so requester 0
  // takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // Memory port: address/data simply follow the latched access so they
  // hold their last value between accesses; write enable only in ACCESS.
  always_comb begin
    mem_we = access_live & we_q;
    mem_a  = addr_q;
    mem_wd = wdata_q;
  end

  // Grant pulses and registered read responses.
  always_comb begin
    gnt0    = access_live & ~owner_q;
    gnt1    = access_live & owner_q;
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters, bumped at the edge that ends an ACCESS.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (in_access) begin
      if (!owner_q && (cnt0_q != {CNT_W{1'b1}})) begin
        cnt0_d = cnt0_q + 1'b1;
      end
      if (owner_q && (cnt1_q != {CNT_W{1'b1}})) begin
        cnt1_d = cnt1_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a round-robin instance driven through a
// grant/read scoreboard, plus a fixed-priority instance for the
// starvation case. Counter checks are compiled in with DMEM_ARB_PERF_EN.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // round-robin instance
  logic        req0, we0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [3:0]  cnt0, cnt1;

  // fixed-priority instance
  logic        req0_f, we0_f, gnt0_f, rvalid0_f;
  logic [31:0] addr0_f, wdata0_f, rdata0_f;
  logic        req1_f, we1_f, gnt1_f, rvalid1_f;
  logic [31:0] addr1_f, wdata1_f, rdata1_f;
  logic        mem_we_f;
  logic [31:0] mem_a_f, mem_wd_f, mem_rd_f;
  logic [15:0] cnt0_f, cnt1_f;

  data_mem_arbiter #(.DATA(32), .ADDR(32), .FIXED_PRIO(0), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_PERF_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  data_mem_arbiter #(.DATA(32), .ADDR(32), .FIXED_PRIO(1), .CNT_W(16)) u_dut_fp (
    .clk(clk), .rst(rst),
    .req0(req0_f), .we0(we0_f), .addr0(addr0_f), .wdata0(wdata0_f),
    .gnt0(gnt0_f), .rvalid0(rvalid0_f), .rdata0(rdata0_f),
    .req1(req1_f), .we1(we1_f), .addr1(addr1_f), .wdata1(wdata1_f),
    .gnt1(gnt1_f), .rvalid1(rvalid1_f), .rdata1(rdata1_f),
    .mem_we(mem_we_f), .mem_a(mem_a_f), .mem_wd(mem_wd_f), .mem_rd(mem_rd_f)
`ifdef DMEM_ARB_PERF_EN
    , .cnt0(cnt0_f), .cnt1(cnt1_f)
`endif
  );

  // memories: combinational read, write at the clock edge
  logic [31:0] mem_r [64];
  logic [31:0] mem_f [64];
  logic [31:0] sh    [64];
  assign mem_rd   = mem_r[mem_a[5:0]];
  assign mem_rd_f = mem_f[mem_a_f[5:0]];
  always @(posedge clk) if (mem_we)   mem_r[mem_a[5:0]]   <= mem_wd;
  always @(posedge clk) if (mem_we_f) mem_f[mem_a_f[5:0]] <= mem_wd_f;

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    bit          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } gexp_t;

  typedef struct {
    bit          who;
    logic [31:0] data;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  // scoreboard monitor for the round-robin instance
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        check("unexp_gnt", 64'({gnt1, gnt0}), 64'd0);
      end else begin
        g = gq.pop_front();
        check("gnt_who", 64'({gnt1, gnt0}), g.who ? 64'd2 : 64'd1);
        check("gnt_cyc", 64'(cyc), 64'(g.cyc));
        check("mem_we", 64'(mem_we), 64'(g.we));
        check("mem_a", 64'(mem_a), 64'(g.addr));
        if (g.we) check("mem_wd", 64'(mem_wd), 64'(g.wdata));
      end
    end else if (mem_we) begin
      check("we_no_gnt", 64'(mem_we), 64'd0);
    end
    if (rvalid0 || rvalid1) begin
      if (rq.size() == 0) begin
        check("unexp_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
      end else begin
        r = rq.pop_front();
        check("rvalid_who", 64'({rvalid1, rvalid0}), r.who ? 64'd2 : 64'd1);
        check("rvalid_cyc", 64'(cyc), 64'(r.cyc));
        check("rdata", r.who ? 64'(rdata1) : 64'(rdata0), 64'(r.data));
      end
    end
  end

  task automatic set_req(input bit who, input bit v);
    if (who) req1 = v;
    else     req0 = v;
  endtask

  task automatic drive(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (who) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // record the expected grant (and read response) for a request driven now
  task automatic expect_acc(input bit who, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input int gcyc);
    gexp_t g;
    rexp_t r;
    g = '{who, we, a, d, gcyc};
    gq.push_back(g);
    if (!we) begin
      r = '{who, sh[a[5:0]], gcyc + 1};
      rq.push_back(r);
    end else begin
      sh[a[5:0]] = d;
    end
  endtask

  task automatic wait_gnt(input bit who);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (who ? gnt1 : gnt0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("gnt_timeout", 64'd0, 64'd1);
  endtask

  task automatic xact(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    drive(who, we, a, d);
    expect_acc(who, we, a, d, cyc + 1);
    wait_gnt(who);
    @(posedge clk); #1;
    set_req(who, 1'b0);
  endtask

  // hold a request, drop it the cycle after each grant, re-raise a cycle later
  task automatic rep(input bit who, input int n);
    for (int i = 0; i < n; i++) begin
      wait_gnt(who);
      @(posedge clk); #1;
      set_req(who, 1'b0);
      if (i < n - 1) begin
        @(posedge clk); #1;
        set_req(who, 1'b1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n_g0;
    bit seen;

    for (int i = 0; i < 64; i++) begin
      mem_r[i] = init_val(i);
      mem_f[i] = init_val(i);
      sh[i]    = init_val(i);
    end
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h11; wdata1 = '0;
    req0_f = 1'b0; we0_f = 1'b0; addr0_f = '0; wdata0_f = '0;
    req1_f = 1'b0; we1_f = 1'b0; addr1_f = '0; wdata1_f = '0;

    // 1: reset with both requests high, then first grants after release
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 64'({gnt1, gnt0}), 64'd0);
      check("rst_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_rdata0", 64'(rdata0), 64'd0);
      check("rst_rdata1", 64'(rdata1), 64'd0);
      check("rst_mem_a", 64'(mem_a), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    k = cyc;
    expect_acc(1'b0, 1'b0, 32'h10, 32'h0, k + 1);
    expect_acc(1'b1, 1'b0, 32'h11, 32'h0, k + 3);
    @(posedge clk); #1;
    @(posedge clk); #1; req0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; req1 = 1'b0;

    // 2: write by requester 0, read back by requester 1
    xact(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    xact(1'b1, 1'b0, 32'd5, 32'h0);
    repeat (2) @(negedge clk);
    check("t2_mem5", 64'(mem_r[5]), 64'hDEAD_BEEF);
    check("t2_rdata1_hold", 64'(rdata1), 64'hDEAD_BEEF);
    check("t2_rdata0_hold", 64'(rdata0), 64'(init_val(16)));

    // 3: both requesters re-requesting -> alternating grants every 2 cycles
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b0, 32'h21, 32'h0);
    k = cyc;
    expect_acc(1'b0, 1'b0, 32'h20, 32'h0, k + 1);
    expect_acc(1'b1, 1'b0, 32'h21, 32'h0, k + 3);
    expect_acc(1'b0, 1'b0, 32'h20, 32'h0, k + 5);
    expect_acc(1'b1, 1'b0, 32'h21, 32'h0, k + 7);
    fork
      rep(1'b0, 2);
      rep(1'b1, 2);
    join

    // tie right after a requester-0 grant goes to requester 1
    xact(1'b0, 1'b1, 32'h30, 32'h5555_AAAA);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h30, 32'h0);
    drive(1'b1, 1'b0, 32'h31, 32'h0);
    k = cyc;
    expect_acc(1'b1, 1'b0, 32'h31, 32'h0, k + 1);
    expect_acc(1'b0, 1'b0, 32'h30, 32'h0, k + 3);
    fork
      rep(1'b1, 1);
      rep(1'b0, 1);
    join

    // 4: fixed priority, requester 0 continuously requesting starves requester 1
    @(posedge clk); #1;
    req0_f = 1'b1; addr0_f = 32'd2;
    req1_f = 1'b1; addr1_f = 32'd3;
    n_g0 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fp_gnt1_starved", 64'(gnt1_f), 64'd0);
      if (gnt0_f) n_g0++;
    end
    check("fp_gnt0_count", 64'(n_g0), 64'd6);
    @(posedge clk); #1;
    req0_f = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (gnt1_f) begin
        seen = 1'b1;
        break;
      end
    end
    check("fp_gnt1_after_release", 64'(seen), 64'd1);
    @(posedge clk); #1;
    req1_f = 1'b0;
    @(negedge clk);
    check("fp_rvalid1", 64'(rvalid1_f), 64'd1);
    check("fp_rdata1", 64'(rdata1_f), 64'(init_val(3)));

    // 5: reset during the ACCESS cycle of a write drops it
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'd7, 32'h0000_1234);
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("t5_mem_we", 64'(mem_we), 64'd0);
    check("t5_gnt", 64'({gnt1, gnt0}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_post_gnt", 64'({gnt1, gnt0}), 64'd0);
      check("t5_post_rvalid", 64'({rvalid1, rvalid0}), 64'd0);
    end
    check("t5_mem7", 64'(mem_r[7]), 64'(init_val(7)));
    check("t5_mem_a", 64'(mem_a), 64'd0);
    check("t5_mem_wd", 64'(mem_wd), 64'd0);

`ifdef DMEM_ARB_PERF_EN
    // 6: grant counters with saturation
    check("cnt0_reset", 64'(cnt0), 64'd0);
    check("cnt1_reset", 64'(cnt1), 64'd0);
    for (int i = 0; i < 10; i++) xact(1'b0, 1'b0, 32'(i), 32'h0);
    for (int i = 0; i < 3; i++)  xact(1'b1, 1'b0, 32'(40 + i), 32'h0);
    check("cnt0_10", 64'(cnt0), 64'd10);
    check("cnt1_3", 64'(cnt1), 64'd3);
    for (int i = 0; i < 20; i++) xact(1'b0, 1'b0, 32'(i), 32'h0);
    check("cnt0_sat", 64'(cnt0), 64'd15);
    check("cnt1_keep", 64'(cnt1), 64'd3);
`endif

    repeat (4) @(negedge clk);
    check("sb_gq_empty", 64'(gq.size()), 64'd0);
    check("sb_rq_empty", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
